// File: rtl/mux8way16_collector.sv
// mux8way16_collector
// Eight-channel collector feeding a single-entry output register. Each cycle
// the register can accept a new word, one requesting channel is granted,
// acknowledged combinationally, and its word is captured together with its
// 3-bit channel index (same encoding as the 8-way demux select).
//
// Build option: define MUX8WAY16_RR_EN for round-robin arbitration driven by
// a "last granted" pointer; leave it undefined for fixed priority where the
// lowest requesting index always wins.
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | output register holds no untaken word
// FULL  | out/out_sel hold a word not yet taken downstream

module mux8way16_collector #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_valid,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [WIDTH-1:0] in5,
    input  logic [WIDTH-1:0] in6,
    input  logic [WIDTH-1:0] in7,
    output logic [7:0]       in_ack,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       out_sel,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] chan_data [8];
    logic [WIDTH-1:0] grant_data;
    logic [2:0]       grant_idx;
    logic             grant_any;
    logic             grant_fire;
    logic             load;

    assign chan_data[0] = in0;
    assign chan_data[1] = in1;
    assign chan_data[2] = in2;
    assign chan_data[3] = in3;
    assign chan_data[4] = in4;
    assign chan_data[5] = in5;
    assign chan_data[6] = in6;
    assign chan_data[7] = in7;

    assign out_valid = (state == FULL);

    // The register can take a word when empty, or when its current word
    // retires at this same edge.
    assign load = (state == EMPTY) || out_ready;

`ifdef MUX8WAY16_RR_EN
    logic [2:0] last;
    logic [2:0] cand;

    // Round-robin search: start just after the last granted channel and
    // wrap 7->0, so the most recently served channel is looked at last.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 3'd0;
        cand      = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            cand = last + 3'(k);
            if (!grant_any && in_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Pointer advances only on an actual grant; reset value 7 makes
    // channel 0 the first candidate after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= 3'd7;
        end else if (grant_fire) begin
            last <= grant_idx;
        end
    end
`else
    // Fixed priority: scan from the top so the lowest requesting index
    // is the one left in grant_idx.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (in_valid[k]) begin
                grant_any = 1'b1;
                grant_idx = 3'(k);
            end
        end
    end
`endif

    assign grant_data = chan_data[grant_idx];

    // No ack may escape while reset is held, even though the arbiter
    // itself keeps evaluating the live requests.
    assign grant_fire = load && grant_any && !reset;

    // One-hot acknowledge of the winning channel for this edge.
    assign in_ack = grant_fire ? (8'd1 << grant_idx) : 8'd0;

    // Output register: capture the winner, drain to EMPTY when nothing is
    // requesting, hold everything while stalled by downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= EMPTY;
            out     <= '0;
            out_sel <= 3'd0;
        end else if (load) begin
            if (grant_any) begin
                state   <= FULL;
                out     <= grant_data;
                out_sel <= grant_idx;
            end else begin
                state   <= EMPTY;
            end
        end
    end

    // Ack is at most one-hot.
    a_ack_onehot : assert property (@(posedge clk) $onehot0(in_ack));

    // Ack only goes to a channel that is actually requesting.
    a_ack_requested : assert property (@(posedge clk) (in_ack & ~in_valid) == 8'd0);

    // A stalled word is never disturbed.
    a_hold_stalled : assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=> (out_valid && $stable(out) && $stable(out_sel)));

endmodule

// File: tb/tb_mux8way16_collector.sv
// Bench for mux8way16_collector: directed scenarios with literal expectations,
// then randomized traffic compared cycle by cycle against a behavioural model.
`timescale 1ns/1ps

module tb_mux8way16_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_valid;
    logic [15:0] din [8];
    logic [7:0]  in_ack;
    logic [15:0] out;
    logic [2:0]  out_sel;
    logic        out_valid;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    // Behavioural model of the output register and arbiter pointer
    logic [15:0] m_out;
    logic [2:0]  m_sel;
    logic        m_valid;
`ifdef MUX8WAY16_RR_EN
    int          m_last;
`endif
    int          last_w;

    always #5 clk = ~clk;

    mux8way16_collector #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (rst),
        .in_valid  (in_valid),
        .in0       (din[0]),
        .in1       (din[1]),
        .in2       (din[2]),
        .in3       (din[3]),
        .in4       (din[4]),
        .in5       (din[5]),
        .in6       (din[6]),
        .in7       (din[7]),
        .in_ack    (in_ack),
        .out       (out),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out   = 16'h0000;
        m_sel   = 3'd0;
        m_valid = 1'b0;
`ifdef MUX8WAY16_RR_EN
        m_last  = 7;
`endif
    endtask

    // Winner among requesting channels, -1 when none request
    function automatic int pick(input logic [7:0] r);
`ifdef MUX8WAY16_RR_EN
        for (int k = 1; k <= 8; k++) begin
            int c;
            c = (m_last + k) % 8;
            if (r[c]) return c;
        end
`else
        for (int c = 0; c < 8; c++) begin
            if (r[c]) return c;
        end
`endif
        return -1;
    endfunction

    // One clock cycle: compare DUT against model before the edge, advance
    // the model at the edge, return at the following falling edge.
    task automatic step();
        int         w;
        logic       ld;
        logic [7:0] ea;
        #1;
        if (rst) model_reset();
        ld = !m_valid || out_ready;
        w  = -1;
        if (!rst && ld) w = pick(in_valid);
        ea = (w >= 0) ? (8'd1 << w) : 8'd0;
        chk("in_ack", {24'd0, in_ack}, {24'd0, ea});
        chk("out", {16'd0, out}, {16'd0, m_out});
        chk("out_sel", {29'd0, out_sel}, {29'd0, m_sel});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        @(posedge clk);
        if (!rst && ld) begin
            if (w >= 0) begin
                m_out   = din[w];
                m_sel   = 3'(w);
                m_valid = 1'b1;
`ifdef MUX8WAY16_RR_EN
                m_last  = w;
`endif
            end else begin
                m_valid = 1'b0;
            end
        end
        last_w = w;
        @(negedge clk);
    endtask

    // Random sources: an acked source either offers a new word or drops;
    // idle sources occasionally start a request; data held while pending.
    task automatic sources_update(input int w);
        for (int c = 0; c < 8; c++) begin
            if (c == w) begin
                if ($urandom_range(0, 1) == 1) din[c] = 16'($urandom);
                else in_valid[c] = 1'b0;
            end else if (!in_valid[c] && $urandom_range(0, 3) == 0) begin
                in_valid[c] = 1'b1;
                din[c]      = 16'($urandom);
            end
        end
        out_ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        int seq [9];
        rst       = 1'b1;
        in_valid  = 8'($urandom);
        out_ready = 1'($urandom);
        for (int c = 0; c < 8; c++) din[c] = 16'($urandom);
        model_reset();
        last_w = -1;

        // Reset with arbitrary inputs
        @(negedge clk);
        chk("rst_out", {16'd0, out}, 32'h0000);
        chk("rst_sel", {29'd0, out_sel}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ack", {24'd0, in_ack}, 32'h00);
        step();
        rst       = 1'b0;
        in_valid  = 8'h00;
        out_ready = 1'b0;
        step();
        step();
        chk("idle_out", {16'd0, out}, 32'h0000);
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_ack", {24'd0, in_ack}, 32'h00);

        // Single grant from channel 5
        in_valid  = 8'b0010_0000;
        din[5]    = 16'h0546;
        out_ready = 1'b1;
        #1;
        chk("single_ack", {24'd0, in_ack}, 32'b0010_0000);
        step();
        in_valid = 8'h00;
        chk("single_out", {16'd0, out}, 32'h0546);
        chk("single_sel", {29'd0, out_sel}, 32'd5);
        chk("single_valid", {31'd0, out_valid}, 32'd1);

        // Backpressure
        in_valid = 8'b0000_1000;
        din[3]   = 16'h0F1C;
        step();
        in_valid  = 8'b0000_0100;
        din[2]    = 16'h85C2;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ack", {24'd0, in_ack}, 32'h00);
            step();
            chk("stall_out", {16'd0, out}, 32'h0F1C);
        end
        out_ready = 1'b1;
        #1;
        chk("release_ack", {24'd0, in_ack}, 32'b0000_0100);
        step();
        in_valid = 8'h00;
        chk("release_out", {16'd0, out}, 32'h85C2);
        chk("release_sel", {29'd0, out_sel}, 32'd2);

        // Fairness with all channels requesting, starting from reset
        rst = 1'b1;
        step();
        rst       = 1'b0;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) din[c] = 16'h1000 + 16'(c);
        for (int i = 0; i < 9; i++) begin
            step();
            seq[i] = int'(out_sel);
        end
        for (int i = 0; i < 9; i++) begin
`ifdef MUX8WAY16_RR_EN
            chk("fair_seq", 32'(seq[i]), 32'(i % 8));
`else
            chk("fair_seq", 32'(seq[i]), 32'd0);
`endif
        end

`ifdef MUX8WAY16_RR_EN
        // Wrap-around after a grant to channel 6
        in_valid = 8'b0100_0000;
        step();
        in_valid = 8'b0000_1010;
        step();
        chk("wrap_1", {29'd0, out_sel}, 32'd1);
        step();
        chk("wrap_3", {29'd0, out_sel}, 32'd3);
        step();
        chk("wrap_1b", {29'd0, out_sel}, 32'd1);
`endif

        // Reset in the middle of a FULL stall
        in_valid = 8'b0001_0000;
        din[4]   = 16'h4444;
        step();
        in_valid  = 8'h00;
        out_ready = 1'b0;
        chk("mid_full_sel", {29'd0, out_sel}, 32'd4);
        chk("mid_full_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_ack", {24'd0, in_ack}, 32'h00);
        in_valid = 8'b0001_0001;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        chk("post_rst_sel", {29'd0, out_sel}, 32'd0);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);

        // Randomized traffic against the model
        in_valid = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 199) == 0) rst = 1'b1;
            step();
            sources_update(last_w);
        end
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
